// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - IF/ID and PC hazard controller with stall/flush counters
module pipeline_hazard_ctrl #(
  parameter int FLUSH_CYCLES = 1,
  parameter int IMEM_TIMEOUT = 64,
  parameter int CNT_W        = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [4:0]       i_ifid_rs,
  input  logic [4:0]       i_ifid_rt,
  input  logic             i_ifid_uses_rt,
  input  logic             i_idex_mem_read,
  input  logic [4:0]       i_idex_rt,
  input  logic             i_ex_branch_taken,
  input  logic             i_imem_ready,
  input  logic             i_dmem_busy,
  output logic             o_pc_write,
  output logic             o_ifid_enable,
  output logic             o_ifid_flush,
  output logic             o_idex_bubble,
  output logic             o_pipe_freeze,
  output logic             o_fetch_timeout,
  output logic [CNT_W-1:0] o_stall_cycles,
  output logic [CNT_W-1:0] o_flush_events
);

  localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES + 1) : 1;
  localparam int WT_W = (IMEM_TIMEOUT > 1) ? $clog2(IMEM_TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {S_RUN, S_FLUSH, S_FETCH_WAIT} state_t;

  state_t           r_state;
  logic [FC_W-1:0]  r_flush_cnt;
  logic [WT_W-1:0]  r_wait_cnt;
  logic             r_fetch_timeout;
  logic [CNT_W-1:0] r_stall_cycles;
  logic [CNT_W-1:0] r_flush_events;

  logic            w_load_use;
  logic            w_redirect;
  logic            w_in_flush;
  logic            w_lu_stall;
  logic            w_fetch_wait;
  logic [WT_W-1:0] w_wait_next;

  assign w_load_use = i_idex_mem_read && (i_idex_rt != 5'd0) &&
                      ((i_idex_rt == i_ifid_rs) || (i_ifid_uses_rt && (i_idex_rt == i_ifid_rt)));

  // A redirect is refused during FLUSH because EX then only holds bubbles.
  assign w_redirect   = !i_dmem_busy && i_ex_branch_taken && (r_state != S_FLUSH);
  assign w_in_flush   = !i_dmem_busy && (r_state == S_FLUSH);
  assign w_lu_stall   = !i_dmem_busy && !w_redirect && !w_in_flush && w_load_use &&
                        ((r_state == S_RUN) || i_imem_ready);
  assign w_fetch_wait = !i_dmem_busy && !w_redirect && !w_in_flush && !w_lu_stall && !i_imem_ready;

  assign w_wait_next = (r_state != S_FETCH_WAIT) ? WT_W'(1) :
                       (r_wait_cnt == WT_W'(IMEM_TIMEOUT)) ? r_wait_cnt : r_wait_cnt + WT_W'(1);

  always_comb begin
    o_pc_write    = 1'b0;
    o_ifid_enable = 1'b0;
    o_ifid_flush  = 1'b0;
    o_idex_bubble = 1'b0;
    o_pipe_freeze = 1'b0;
    if (i_reset) begin
      o_ifid_flush  = 1'b1;
      o_idex_bubble = 1'b1;
    end else if (i_dmem_busy) begin
      o_pipe_freeze = 1'b1;
    end else if (w_redirect || w_in_flush) begin
      o_pc_write    = 1'b1;
      o_ifid_enable = 1'b1;
      o_ifid_flush  = 1'b1;
      o_idex_bubble = 1'b1;
    end else if (w_lu_stall) begin
      o_idex_bubble = 1'b1;
    end else if (w_fetch_wait) begin
      o_ifid_enable = 1'b1;
      o_ifid_flush  = 1'b1;
    end else begin
      o_pc_write    = 1'b1;
      o_ifid_enable = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state         <= S_RUN;
      r_flush_cnt     <= '0;
      r_wait_cnt      <= '0;
      r_fetch_timeout <= 1'b0;
      r_stall_cycles  <= '0;
      r_flush_events  <= '0;
    end else begin
      if (!o_pc_write && (r_stall_cycles != {CNT_W{1'b1}}))
        r_stall_cycles <= r_stall_cycles + CNT_W'(1);
      if (w_redirect) begin
        if (r_flush_events != {CNT_W{1'b1}})
          r_flush_events <= r_flush_events + CNT_W'(1);
        r_wait_cnt <= '0;
        if (FLUSH_CYCLES > 1) begin
          r_state     <= S_FLUSH;
          r_flush_cnt <= FC_W'(FLUSH_CYCLES - 1);
        end else begin
          r_state <= S_RUN;
        end
      end else if (w_in_flush) begin
        r_flush_cnt <= r_flush_cnt - FC_W'(1);
        if (r_flush_cnt == FC_W'(1))
          r_state <= S_RUN;
      end else if (w_fetch_wait) begin
        r_state    <= S_FETCH_WAIT;
        r_wait_cnt <= w_wait_next;
        if (w_wait_next == WT_W'(IMEM_TIMEOUT))
          r_fetch_timeout <= 1'b1;
      end else if (!i_dmem_busy) begin
        r_state    <= S_RUN;
        r_wait_cnt <= '0;
      end
    end
  end

  assign o_fetch_timeout = r_fetch_timeout;
  assign o_stall_cycles  = r_stall_cycles;
  assign o_flush_events  = r_flush_events;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - directed self-checking bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic [4:0]       ifid_rs, ifid_rt, idex_rt;
  logic             ifid_uses_rt, idex_mem_read, ex_branch_taken, imem_ready, dmem_busy;
  logic             pc_write, ifid_enable, ifid_flush, idex_bubble, pipe_freeze, fetch_timeout;
  logic [CNT_W-1:0] stall_cycles, flush_events;
  logic [4:0]       ctl;

  int n_tests = 0;
  int n_fail  = 0;

  // ctl = {pc_write, ifid_enable, ifid_flush, idex_bubble, pipe_freeze}
  localparam logic [4:0] C_RESET = 5'b00110;
  localparam logic [4:0] C_RUN   = 5'b11000;
  localparam logic [4:0] C_LU    = 5'b00010;
  localparam logic [4:0] C_FLUSH = 5'b11110;
  localparam logic [4:0] C_WAIT  = 5'b01100;
  localparam logic [4:0] C_FRZ   = 5'b00001;

  assign ctl = {pc_write, ifid_enable, ifid_flush, idex_bubble, pipe_freeze};

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.FLUSH_CYCLES(3), .IMEM_TIMEOUT(8), .CNT_W(CNT_W)) dut (
    .i_clk(clk), .i_reset(reset),
    .i_ifid_rs(ifid_rs), .i_ifid_rt(ifid_rt), .i_ifid_uses_rt(ifid_uses_rt),
    .i_idex_mem_read(idex_mem_read), .i_idex_rt(idex_rt),
    .i_ex_branch_taken(ex_branch_taken), .i_imem_ready(imem_ready), .i_dmem_busy(dmem_busy),
    .o_pc_write(pc_write), .o_ifid_enable(ifid_enable), .o_ifid_flush(ifid_flush),
    .o_idex_bubble(idex_bubble), .o_pipe_freeze(pipe_freeze), .o_fetch_timeout(fetch_timeout),
    .o_stall_cycles(stall_cycles), .o_flush_events(flush_events)
  );

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc_ctl(input string tag, input logic [4:0] exp);
    @(negedge clk);
    chk(tag, {11'd0, ctl}, {11'd0, exp});
    adv();
  endtask

  initial begin
    reset = 1'b1; ifid_rs = 5'd0; ifid_rt = 5'd0; idex_rt = 5'd0;
    ifid_uses_rt = 1'b0; idex_mem_read = 1'b0; ex_branch_taken = 1'b0;
    imem_ready = 1'b1; dmem_busy = 1'b0;

    cyc_ctl("reset_ctl", C_RESET);
    chk("reset_stall", 16'(stall_cycles), 16'd0);
    chk("reset_flushev", 16'(flush_events), 16'd0);
    chk("reset_timeout", 16'(fetch_timeout), 16'd0);

    reset = 1'b0;
    cyc_ctl("run_ctl", C_RUN);
    chk("run_stall", 16'(stall_cycles), 16'd0);

    // load-use on rs
    idex_mem_read = 1'b1; idex_rt = 5'd5; ifid_rs = 5'd5;
    cyc_ctl("lu_rs_ctl", C_LU);
    idex_mem_read = 1'b0;
    cyc_ctl("lu_after_ctl", C_RUN);
    chk("lu_stall", 16'(stall_cycles), 16'd1);

    // load of $0 never stalls
    idex_mem_read = 1'b1; idex_rt = 5'd0; ifid_rs = 5'd0;
    cyc_ctl("lw0_ctl_a", C_RUN);
    cyc_ctl("lw0_ctl_b", C_RUN);
    chk("lw0_stall", 16'(stall_cycles), 16'd1);

    // rt match only counts when rt is a source
    idex_rt = 5'd7; ifid_rs = 5'd3; ifid_rt = 5'd7; ifid_uses_rt = 1'b0;
    cyc_ctl("rt_unused_ctl", C_RUN);
    ifid_uses_rt = 1'b1;
    cyc_ctl("rt_used_ctl", C_LU);
    idex_mem_read = 1'b0; ifid_uses_rt = 1'b0;
    chk("rt_stall", 16'(stall_cycles), 16'd2);

    // branch with FLUSH_CYCLES=3; redirect during FLUSH is ignored
    ex_branch_taken = 1'b1;
    cyc_ctl("br_ctl_1", C_FLUSH);
    ex_branch_taken = 1'b0;
    cyc_ctl("br_ctl_2", C_FLUSH);
    ex_branch_taken = 1'b1;
    cyc_ctl("br_ctl_3", C_FLUSH);
    ex_branch_taken = 1'b0;
    cyc_ctl("br_ctl_run", C_RUN);
    chk("br_flushev", 16'(flush_events), 16'd1);
    chk("br_stall", 16'(stall_cycles), 16'd2);

    // 4-cycle fetch wait, no timeout
    imem_ready = 1'b0;
    for (int k = 1; k <= 4; k++) cyc_ctl($sformatf("fw4_ctl_%0d", k), C_WAIT);
    imem_ready = 1'b1;
    cyc_ctl("fw4_resume_ctl", C_RUN);
    cyc_ctl("fw4_run_ctl", C_RUN);
    chk("fw4_stall", 16'(stall_cycles), 16'd6);
    chk("fw4_timeout", 16'(fetch_timeout), 16'd0);

    // dmem_busy during FLUSH holds flush_cnt
    ex_branch_taken = 1'b1;
    cyc_ctl("bz_br_ctl", C_FLUSH);
    ex_branch_taken = 1'b0; dmem_busy = 1'b1;
    cyc_ctl("bz_frz_1", C_FRZ);
    cyc_ctl("bz_frz_2", C_FRZ);
    dmem_busy = 1'b0;
    cyc_ctl("bz_fl_2", C_FLUSH);
    cyc_ctl("bz_fl_3", C_FLUSH);
    cyc_ctl("bz_run", C_RUN);
    chk("bz_stall", 16'(stall_cycles), 16'd8);
    chk("bz_flushev", 16'(flush_events), 16'd2);

    // timeout after 8 wait cycles, sticky; stall counter saturates at 15
    imem_ready = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      chk($sformatf("to_ctl_%0d", k), {11'd0, ctl}, {11'd0, C_WAIT});
      chk($sformatf("to_flag_%0d", k), 16'(fetch_timeout), (k > 8) ? 16'd1 : 16'd0);
      adv();
    end
    imem_ready = 1'b1;
    cyc_ctl("to_resume_ctl", C_RUN);
    chk("to_sticky", 16'(fetch_timeout), 16'd1);
    chk("stall_sat", 16'(stall_cycles), 16'd15);

    // reset mid-FETCH_WAIT clears everything
    imem_ready = 1'b0;
    cyc_ctl("rfw_ctl_1", C_WAIT);
    cyc_ctl("rfw_ctl_2", C_WAIT);
    reset = 1'b1;
    cyc_ctl("rfw_reset_ctl", C_RESET);
    reset = 1'b0; imem_ready = 1'b1;
    chk("rfw_timeout", 16'(fetch_timeout), 16'd0);
    chk("rfw_stall", 16'(stall_cycles), 16'd0);
    chk("rfw_flushev", 16'(flush_events), 16'd0);
    cyc_ctl("rfw_run_ctl", C_RUN);

    // redirect from FETCH_WAIT abandons the fetch
    imem_ready = 1'b0;
    cyc_ctl("fwbr_wait_ctl", C_WAIT);
    ex_branch_taken = 1'b1;
    cyc_ctl("fwbr_br_ctl", C_FLUSH);
    ex_branch_taken = 1'b0; imem_ready = 1'b1;
    cyc_ctl("fwbr_fl_2", C_FLUSH);
    cyc_ctl("fwbr_fl_3", C_FLUSH);
    cyc_ctl("fwbr_run", C_RUN);
    chk("fwbr_flushev", 16'(flush_events), 16'd1);
    chk("fwbr_stall", 16'(stall_cycles), 16'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
